// File: rtl/music_seq_ctrl.sv
// rtl/music_seq_ctrl.sv - multi-track background music sequencer with codec init handshake
//
// Drives the sample ROM address for one of NUM_TRACKS tracks packed in a shared ROM.
// The codec init handshake runs once per reset. Address steps are paced by the codec
// data_over strobe divided by DIV. The sequencer supports play/retrigger, stop,
// pause/resume, and loop or one-shot playback.
//
// Ports:
//   Clk          system clock
//   Reset        asynchronous active-low reset
//   play_req     start or retrigger track_sel (pulse)
//   track_sel    track index, sampled with play_req
//   loop_en      loop (1) or one-shot (0), sampled at end of track
//   stop_req     stop playback (pulse)
//   pause_req    toggle pause (pulse)
//   INIT_FINISH  codec init complete
//   data_over    codec consumed one sample (strobe)
//   INIT         codec init request
//   Addr         ROM address
//   cur_track    latched track index
//   playing      high in PLAY
//   paused       high in PAUSE
//   track_done   one-cycle pulse at each end of track
module music_seq_ctrl #(
  parameter int ADDR_W     = 19,
  parameter int NUM_TRACKS = 4,
  parameter int DIV        = 10,
  parameter logic [NUM_TRACKS*ADDR_W-1:0] TRACK_BASE =
    {19'd255345, 19'd170230, 19'd85115, 19'd0},
  parameter logic [NUM_TRACKS*ADDR_W-1:0] TRACK_LAST =
    {19'd340459, 19'd255344, 19'd170229, 19'd85114},
  localparam int TRK_W = (NUM_TRACKS > 1) ? $clog2(NUM_TRACKS) : 1
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              play_req,
  input  logic [TRK_W-1:0]  track_sel,
  input  logic              loop_en,
  input  logic              stop_req,
  input  logic              pause_req,
  input  logic              INIT_FINISH,
  input  logic              data_over,
  output logic              INIT,
  output logic [ADDR_W-1:0] Addr,
  output logic [TRK_W-1:0]  cur_track,
  output logic              playing,
  output logic              paused,
  output logic              track_done
);

  localparam int DW = $clog2(DIV) + 1;
  localparam logic [DW-1:0] DIV_M1 = DW'(DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT_REQ,
    S_WAIT_INIT,
    S_PLAY,
    S_PAUSE
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [TRK_W-1:0]  r_cur_track;
  logic [DW-1:0]     r_div_cnt;
  logic              r_codec_ready;
  logic              r_init;
  logic              r_playing;
  logic              r_paused;
  logic              r_track_done;

  logic              w_play_valid;
  logic [ADDR_W-1:0] w_sel_base;
  logic [ADDR_W-1:0] w_cur_base;
  logic [ADDR_W-1:0] w_cur_last;

  // Table lookup written as a compare loop so an out-of-range index never
  // produces an out-of-bounds part select; unmatched indices return 0.
  function automatic logic [ADDR_W-1:0] track_word(
    input logic [NUM_TRACKS*ADDR_W-1:0] tbl,
    input logic [TRK_W-1:0]             t
  );
    logic [ADDR_W-1:0] v;
    v = '0;
    for (int i = 0; i < NUM_TRACKS; i++) begin
      if (t == TRK_W'(i)) v = tbl[i*ADDR_W +: ADDR_W];
    end
    return v;
  endfunction

  // Track indices beyond the table are ignored in every state.
  assign w_play_valid = play_req &&
                        ({{(32-TRK_W){1'b0}}, track_sel} < 32'(NUM_TRACKS));
  assign w_sel_base   = track_word(TRACK_BASE, track_sel);
  assign w_cur_base   = track_word(TRACK_BASE, r_cur_track);
  assign w_cur_last   = track_word(TRACK_LAST, r_cur_track);

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_state       <= S_IDLE;
      r_addr        <= '0;
      r_cur_track   <= '0;
      r_div_cnt     <= '0;
      r_codec_ready <= 1'b0;
      r_init        <= 1'b0;
      r_playing     <= 1'b0;
      r_paused      <= 1'b0;
      r_track_done  <= 1'b0;
    end else begin
      r_track_done <= 1'b0;
      r_init       <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_play_valid) begin
            r_cur_track <= track_sel;
            r_addr      <= w_sel_base;
            r_div_cnt   <= '0;
            if (r_codec_ready) begin
              r_state   <= S_PLAY;
              r_playing <= 1'b1;
            end else begin
              r_state <= S_INIT_REQ;
              r_init  <= 1'b1;
            end
          end
        end

        S_INIT_REQ: begin
          r_state <= S_WAIT_INIT;
        end

        S_WAIT_INIT: begin
          if (stop_req) begin
            r_state   <= S_IDLE;
            r_addr    <= '0;
            r_div_cnt <= '0;
          end else begin
            if (w_play_valid) begin
              r_cur_track <= track_sel;
              r_addr      <= w_sel_base;
              r_div_cnt   <= '0;
            end
            if (INIT_FINISH) begin
              r_codec_ready <= 1'b1;
              r_state       <= S_PLAY;
              r_playing     <= 1'b1;
            end
          end
        end

        S_PLAY: begin
          if (stop_req) begin
            r_state   <= S_IDLE;
            r_addr    <= '0;
            r_div_cnt <= '0;
            r_playing <= 1'b0;
          end else if (w_play_valid) begin
            // Retrigger wins over a coincident sample strobe.
            r_cur_track <= track_sel;
            r_addr      <= w_sel_base;
            r_div_cnt   <= '0;
          end else if (pause_req) begin
            // A coincident data_over is dropped so the paused position is exact.
            r_state   <= S_PAUSE;
            r_playing <= 1'b0;
            r_paused  <= 1'b1;
          end else if (data_over) begin
            if (r_div_cnt < DIV_M1) begin
              r_div_cnt <= r_div_cnt + 1'b1;
            end else begin
              r_div_cnt <= '0;
              if (r_addr < w_cur_last) begin
                r_addr <= r_addr + 1'b1;
              end else begin
                r_track_done <= 1'b1;
                if (loop_en) begin
                  r_addr <= w_cur_base;
                end else begin
                  r_state   <= S_IDLE;
                  r_addr    <= '0;
                  r_playing <= 1'b0;
                end
              end
            end
          end
        end

        S_PAUSE: begin
          if (stop_req) begin
            r_state   <= S_IDLE;
            r_addr    <= '0;
            r_div_cnt <= '0;
            r_paused  <= 1'b0;
          end else if (w_play_valid) begin
            r_cur_track <= track_sel;
            r_addr      <= w_sel_base;
            r_div_cnt   <= '0;
            r_state     <= S_PLAY;
            r_playing   <= 1'b1;
            r_paused    <= 1'b0;
          end else if (pause_req) begin
            r_state   <= S_PLAY;
            r_playing <= 1'b1;
            r_paused  <= 1'b0;
          end
        end

        default: begin
          r_state   <= S_IDLE;
          r_addr    <= '0;
          r_div_cnt <= '0;
          r_playing <= 1'b0;
          r_paused  <= 1'b0;
        end
      endcase
    end
  end

  assign INIT       = r_init;
  assign Addr       = r_addr;
  assign cur_track  = r_cur_track;
  assign playing    = r_playing;
  assign paused     = r_paused;
  assign track_done = r_track_done;

endmodule
